mem_arbiter: RTL and testbench

//  Sits directly downstream of the CPU top's dual memory interface (port 1 = I-cache, port 0 = D-cache).

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port byte-serialising memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int PORT_D = 0;
  localparam int PORT_I = 1;
  localparam logic [1:0] LAST_BEAT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// 2-way grant: cooldown-masked requests -> one-hot grant, combinational.
// Ties rotate on last_grant, or go to port0 when MEM_ARB_DPRIO_EN is defined.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] cool,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic [1:0] elig;
  assign elig = req & ~cool;

`ifdef MEM_ARB_DPRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef MEM_ARB_DPRIO_EN
        grant = port_onehot(1'(PORT_D));
`else
        grant = port_onehot(~last_grant);
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache (port1) and D-cache (port0) onto a byte-wide RAM, 4 beats per word.
// Read done at t0+6, write at t0+5; losers hold their request; tie policy set by MEM_ARB_DPRIO_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_rwe_i,
  input  logic [63:0]       mem_addr_i,
  input  logic [7:0]        mem_sel_i,
  input  logic [63:0]       mem_data_i,
  output logic [63:0]       mem_data_o,
  output logic [1:0]        mem_busy_o,
  output logic [1:0]        mem_done_o,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t                  state_q, state_d;
  logic [1:0]              beat_q;
  logic                    port_q, last_grant_q, busy_q;
  logic [1:0]              cool_q;
  logic [RAM_AW-3:0]       base_q;
  logic [MEM_DW-1:0]       wdata_q;
  logic [3:0]              sel_q;
  logic [23:0]             rd_buf_q;
  logic [1:0][MEM_DW-1:0]  rdata_q;

  logic [1:0]              req, grant;
  logic                    grant_vld, gnt_port, gnt_we;
  logic [MEM_AW-1:0]       gnt_addr;
  logic                    unused_addr_bits;

  assign req = {mem_rwe_i[3] | mem_rwe_i[2], mem_rwe_i[1] | mem_rwe_i[0]};

  mem_arb_rr u_arb (
    .req        (req),
    .cool       (cool_q),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign grant_vld = (state_q == ST_IDLE) && (grant != 2'b00);
  assign gnt_port  = grant[PORT_I];
  // we bit beats re bit when a port raises both
  assign gnt_we    = gnt_port ? mem_rwe_i[3] : mem_rwe_i[1];
  assign gnt_addr  = gnt_port ? mem_addr_i[63:32] : mem_addr_i[31:0];
  assign unused_addr_bits = ^{gnt_addr[MEM_AW-1:RAM_AW], gnt_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_vld) state_d = gnt_we ? ST_WRITE : ST_READ;
      ST_READ:    if (beat_q == LAST_BEAT) state_d = ST_CAPTURE;
      ST_WRITE:   if (beat_q == LAST_BEAT) state_d = ST_DONE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    mem_done_o = 2'b00;
    case (state_q)
      ST_READ: begin
        ram_en   = 1'b1;
        ram_addr = {base_q, beat_q};
      end
      ST_WRITE: begin
        // masked beats still occupy their slot so write timing never varies
        ram_en    = 1'b1;
        ram_we    = sel_q[beat_q];
        ram_addr  = {base_q, beat_q};
        ram_wdata = wdata_q[{beat_q, 3'b000} +: 8];
      end
      ST_DONE:  mem_done_o = port_onehot(port_q);
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q       <= 2'd0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      cool_q       <= 2'b00;
      base_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= 4'h0;
      rd_buf_q     <= '0;
      rdata_q      <= '0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      cool_q <= mem_done_o;
      if (grant_vld) begin
        port_q       <= gnt_port;
        last_grant_q <= gnt_port;
        base_q       <= gnt_addr[RAM_AW-1:2];
        wdata_q      <= gnt_port ? mem_data_i[63:32] : mem_data_i[31:0];
        sel_q        <= gnt_port ? mem_sel_i[7:4] : mem_sel_i[3:0];
        beat_q       <= 2'd0;
      end else if (state_q == ST_READ || state_q == ST_WRITE) begin
        beat_q <= beat_q + 2'd1;
      end
      // RAM answers one cycle late: beat k's byte arrives while beat k+1 is issued
      if (state_q == ST_READ) begin
        case (beat_q)
          2'd1:    rd_buf_q[7:0]   <= ram_rdata;
          2'd2:    rd_buf_q[15:8]  <= ram_rdata;
          2'd3:    rd_buf_q[23:16] <= ram_rdata;
          default: ;
        endcase
      end
      if (state_q == ST_CAPTURE) rdata_q[port_q] <= {ram_rdata, rd_buf_q};
    end
  end

  assign mem_busy_o = {2{busy_q}};
  assign mem_data_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus cycle-exact sequences, done pulses scored from a queue.
module tb_mem_arbiter;

  localparam int AW = 17;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rd_exp;
  } vec_t;

  typedef struct {
    int          port;
    bit          chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    rwe = '0;
  logic [63:0]   addr = '0;
  logic [63:0]   wdata = '0;
  logic [7:0]    sel = '0;
  logic [63:0]   rdata;
  logic [1:0]    busy, done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[11];
  logic [7:0] ram [0:(1<<AW)-1];

  mem_arbiter #(.RAM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rwe_i  (rwe),
    .mem_addr_i (addr),
    .mem_sel_i  (sel),
    .mem_data_i (wdata),
    .mem_data_o (rdata),
    .mem_busy_o (busy),
    .mem_done_o (done),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("done_port", done, (mon_e.port == 1) ? 2'b10 : 2'b01);
        check("done_cycle", cyc, mon_e.due);
        if (mon_e.chk)
          check("rd_data", (mon_e.port == 1) ? rdata[63:32] : rdata[31:0], mon_e.data);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("done_missing", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    rwe[2*p +: 2]    = {we, ~we};
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
    sel[4*p +: 4]     = s;
  endtask

  task automatic release_port(input int p);
    rwe[2*p +: 2] = 2'b00;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_done(input int p, input bit chk, input logic [31:0] d, input int due);
    exp_t e;
    e.port = p;
    e.chk  = chk;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ram[a + AW'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] pair_word(input int p);
    return (p == 1) ? 32'h44332211 : 32'hA3A2A1A0;
  endfunction

  // One request from idle: beat-by-beat RAM bus checks, inputs scrambled after grant.
  task automatic do_txn(input vec_t v);
    int c;
    int lat;
    logic [AW-1:0] base;
    @(negedge clk);
    c    = cyc;
    lat  = v.we ? 5 : 6;
    base = {v.addr[AW-1:2], 2'b00};
    check("busy_idle", busy, 2'b00);
    drive(v.port, v.we, v.addr, v.wdata, v.sel);
    expect_done(v.port, !v.we, v.rd_exp, c + lat);
    for (int k = 0; k < 4; k++) begin
      step_to(c + k + 1);
      check("ram_en", ram_en, 1'b1);
      check("ram_addr", ram_addr, base + AW'(k));
      check("ram_we", ram_we, v.we && v.sel[k]);
      if (v.we && v.sel[k]) check("ram_wdata", ram_wdata, v.wdata[8*k +: 8]);
      if (k == 0) begin
        check("busy_active", busy, 2'b11);
        drive(v.port, v.we, ~v.addr, ~v.wdata, ~v.sel);
      end
    end
    step_to(c + lat);
    release_port(v.port);
    step_to(c + lat + 2);
  endtask

  // Both ports read in the same idle cycle; loser is granted the cycle after the winner's done.
  task automatic do_pair(input int first);
    int c;
    int second;
    second = 1 - first;
    @(negedge clk);
    c = cyc;
    drive(1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    drive(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    expect_done(first, 1'b1, pair_word(first), c + 6);
    expect_done(second, 1'b1, pair_word(second), c + 13);
    step_to(c + 6);
    release_port(first);
    step_to(c + 13);
    release_port(second);
    step_to(c + 15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int first_port;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    preload(17'h00104, 32'h44332211);
    preload(17'h00200, 32'h5A5A5A5A);
    preload(17'h1FFFC, 32'h04030201);
    preload(17'h00500, 32'hA3A2A1A0);
    preload(17'h00600, 32'h77777777);
    preload(17'h00400, 32'hEEEEEEEE);

    tbl[0]  = '{1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h44332211};
    tbl[1]  = '{0, 1'b1, 32'h0000_0200, 32'hAABBCCDD,  4'b0101, 32'h0};
    tbl[2]  = '{0, 1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h5ABB5ADD};
    tbl[3]  = '{1, 1'b0, 32'hFFFF_FFFE, 32'h0,         4'h0, 32'h04030201};
    tbl[4]  = '{0, 1'b1, 32'h0001_FFFD, 32'h12345678,  4'b1111, 32'h0};
    tbl[5]  = '{1, 1'b0, 32'h0001_FFFC, 32'h0,         4'h0, 32'h12345678};
    tbl[6]  = '{0, 1'b0, 32'h0002_0104, 32'h0,         4'h0, 32'h44332211};
    tbl[7]  = '{1, 1'b1, 32'h0000_0300, 32'hFFFFFFFF,  4'b0000, 32'h0};
    tbl[8]  = '{0, 1'b0, 32'h0000_0300, 32'h0,         4'h0, 32'h00000000};
    tbl[9]  = '{1, 1'b1, 32'h0000_0600, 32'hCAFEF00D,  4'b1001, 32'h0};
    tbl[10] = '{1, 1'b0, 32'h0000_0600, 32'h0,         4'h0, 32'hCA77770D};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_done", done, 2'b00);
    check("reset_busy", busy, 2'b00);
    check("reset_data", rdata, 64'h0);
    check("reset_ram_en", ram_en, 1'b0);
    check("reset_ram_we", ram_we, 1'b0);
    check("reset_ram_addr", ram_addr, 0);
    check("reset_ram_wdata", ram_wdata, 8'h00);
    rst = 1'b0;

    // From reset last_grant is 0, so a tie goes to port1 unless port0 has fixed priority.
    first_port = 1;
`ifdef MEM_ARB_DPRIO_EN
    first_port = 0;
`endif
    do_pair(first_port);
    do_txn(tbl[0]);
    // Port1 was granted last, so the tie now goes to port0 in both modes.
    do_pair(0);

    for (int i = 0; i < 11; i++) do_txn(tbl[i]);

    // Port0 holds its request through done, port1 arrives a cycle later.
    @(negedge clk);
    c = cyc;
    drive(0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    expect_done(0, 1'b1, 32'h44332211, c + 6);
    step_to(c + 1);
    drive(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    expect_done(1, 1'b1, 32'hA3A2A1A0, c + 13);
    expect_done(0, 1'b1, 32'h44332211, c + 20);
    step_to(c + 13);
    release_port(1);
    step_to(c + 20);
    release_port(0);
    step_to(c + 22);

    // Lone port0 holding its request sits out one idle cycle after its done.
    @(negedge clk);
    c = cyc;
    drive(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    expect_done(0, 1'b1, 32'hA3A2A1A0, c + 6);
    expect_done(0, 1'b1, 32'hA3A2A1A0, c + 14);
    step_to(c + 7);
    check("cool_idle_busy", busy, 2'b00);
    step_to(c + 8);
    check("cool_no_grant", busy, 2'b00);
    step_to(c + 9);
    check("cool_regrant", busy, 2'b11);
    step_to(c + 14);
    release_port(0);
    step_to(c + 16);

    // Reset during beat 2 of a write: transaction vanishes, earlier beats stay in RAM.
    @(negedge clk);
    c = cyc;
    drive(0, 1'b1, 32'h0000_0400, 32'h11223344, 4'b1111);
    step_to(c + 3);
    rst = 1'b1;
    step_to(c + 4);
    rst = 1'b0;
    release_port(0);
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_busy", busy, 2'b00);
    check("mid_rst_data", rdata, 64'h0);
    check("mid_rst_ram_en", ram_en, 1'b0);
    check("mid_rst_ram_we", ram_we, 1'b0);
    check("mid_rst_ram_addr", ram_addr, 0);
    check("mid_rst_ram_wdata", ram_wdata, 8'h00);
    check("mid_rst_ram400", ram[17'h00400], 8'h44);
    check("mid_rst_ram401", ram[17'h00401], 8'h33);
    check("mid_rst_ram403", ram[17'h00403], 8'hEE);
    step_to(c + 14);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
